// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the multi-cycle MIPS main control FSM:
//               state enum, opcodes, ALUOp, ALU_Src_B, PC_Source and the
//               packed control word. MIPS_CTRL_ADDI_EN adds the addi states.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
`ifdef MIPS_CTRL_ADDI_EN
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
`else
    S_JUMP      = 4'd10
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the FSM knows how to sequence
  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ)   || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_decode
// Description : Combinational state (+ Mem_Ready, Opcode) to control-word
//               decoder. Unlisted outputs are 0 in every state.
//               MIPS_CTRL_ADDI_EN adds the addi execute/writeback words.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Moore control word per state; fetch strobes are qualified by Mem_Ready
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_is_legal(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Main control FSM of the multi-cycle MIPS-32 datapath. Holds
//               the state register and next-state logic; control outputs
//               come from mips_ctrl_decode. Optional macro
//               MIPS_CTRL_ADDI_EN enables the addi (001000) sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       PC_Write_Cond,
  output logic       IorD,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Mem_to_Reg,
  output logic       Reg_Dst,
  output logic       Reg_Write,
  output logic       ALU_Src_A,
  output logic [1:0] ALU_Src_B,
  output logic       ALU_Op1,
  output logic       ALU_Op2,
  output logic [1:0] PC_Source,
  output logic       Illegal_Op
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // Next-state: one phase per clock, memory phases stall on Mem_Ready
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:     state_d = S_FETCH;
      S_FETCH:     state_d = Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (Opcode == OP_SW)      state_d = S_MEM_WRITE;
        else if (Opcode == OP_LW) state_d = S_MEM_READ;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ:  state_d = Mem_Ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = Mem_Ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any in-flight access immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (Mem_Ready),
    .opcode    (Opcode),
    .ctrl      (ctrl)
  );

  assign PC_Write      = ctrl.pc_write;
  assign PC_Write_Cond = ctrl.pc_write_cond;
  assign IorD          = ctrl.iord;
  assign Mem_Read      = ctrl.mem_read;
  assign Mem_Write     = ctrl.mem_write;
  assign IR_Write      = ctrl.ir_write;
  assign Mem_to_Reg    = ctrl.mem_to_reg;
  assign Reg_Dst       = ctrl.reg_dst;
  assign Reg_Write     = ctrl.reg_write;
  assign ALU_Src_A     = ctrl.alu_src_a;
  assign ALU_Src_B     = ctrl.alu_src_b;
  assign ALU_Op1       = ctrl.alu_op[1];
  assign ALU_Op2       = ctrl.alu_op[0];
  assign PC_Source     = ctrl.pc_source;
  assign Illegal_Op    = ctrl.illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Self-checking bench for mips_multicycle_ctrl. Each
//               instruction is expanded into its expected per-clock control
//               words from the opcode, fetch stalls and memory stalls.
//               Honours MIPS_CTRL_ADDI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       Mem_Ready = 1'b0;
  logic       PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write;
  logic       Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A, ALU_Op1, ALU_Op2;
  logic       Illegal_Op;
  logic [1:0] ALU_Src_B, PC_Source;

  int vectors = 0;
  int miscompares = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Mem_to_Reg(Mem_to_Reg), .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op1(ALU_Op1),
    .ALU_Op2(ALU_Op2), .PC_Source(PC_Source), .Illegal_Op(Illegal_Op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op1, alu_op2;
    logic [1:0] pc_source;
    logic       illegal_op;
  } cw_t;

  cw_t obs;
  assign obs = {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write,
                Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A, ALU_Src_B,
                ALU_Op1, ALU_Op2, PC_Source, Illegal_Op};

  // Instruction classes of the reference model
  localparam int K_ILL = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ADDI = 6;

  function automatic int kind(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
`ifdef MIPS_CTRL_ADDI_EN
      6'b001000: return K_ADDI;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  // Expected control words for each datapath phase
  function automatic cw_t w_fetch(input logic rdy);
    cw_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic cw_t w_decode(input logic ill);
    cw_t c = '0;
    c.alu_src_b = 2'b11; c.illegal_op = ill;
    return c;
  endfunction
  function automatic cw_t w_addr();   // lw/sw address and addi execute
    cw_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic cw_t w_mem(input logic wr);
    cw_t c = '0;
    c.iord = 1'b1; c.mem_read = !wr; c.mem_write = wr;
    return c;
  endfunction
  function automatic cw_t w_wb(input logic from_mem, input logic rd);
    cw_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = from_mem; c.reg_dst = rd;
    return c;
  endfunction
  function automatic cw_t w_exec();
    cw_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op1 = 1'b1;
    return c;
  endfunction
  function automatic cw_t w_branch();
    cw_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op2 = 1'b1; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
    return c;
  endfunction
  function automatic cw_t w_jump();
    cw_t c = '0;
    c.pc_write = 1'b1; c.pc_source = 2'b10;
    return c;
  endfunction

  task automatic check(input string tag, input cw_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive Mem_Ready, compare at the falling edge, advance
  task automatic step(input string tag, input logic rdy, input cw_t exp);
    Mem_Ready = rdy;
    @(negedge clk);
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fetch (with fs stall clocks) and decode; returns the instruction class
  task automatic fetch_decode(input logic [5:0] op, input int fs, output int k);
    for (int i = 0; i < fs; i++) begin
      Opcode = 6'($urandom);
      step("fetch_stall", 1'b0, w_fetch(1'b0));
    end
    Opcode = 6'($urandom);
    step("fetch", 1'b1, w_fetch(1'b1));
    Opcode = op;
    k = kind(op);
    step("decode", rnd_bit(), w_decode(k == K_ILL));
  endtask

  // Full instruction from fetch until the FSM is back at fetch
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    int k;
    fetch_decode(op, fs, k);
    case (k)
      K_R: begin
        step("execute", rnd_bit(), w_exec());
        step("alu_wb", rnd_bit(), w_wb(1'b0, 1'b1));
      end
      K_LW, K_SW: begin
        step("mem_addr", rnd_bit(), w_addr());
        Opcode = 6'($urandom);
        for (int i = 0; i < ms; i++) step("mem_stall", 1'b0, w_mem(k == K_SW));
        step("mem_done", 1'b1, w_mem(k == K_SW));
        if (k == K_LW) step("mem_wb", rnd_bit(), w_wb(1'b1, 1'b0));
      end
      K_BEQ:  step("branch", rnd_bit(), w_branch());
      K_J:    step("jump", rnd_bit(), w_jump());
      K_ADDI: begin
        step("addi_exec", rnd_bit(), w_addr());
        step("addi_wb", rnd_bit(), w_wb(1'b0, 1'b0));
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [5:0] op;
    logic [5:0] ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    // Asynchronous reset asserted between clock edges
    #1 reset = 1'b1;
    #1 check("reset_async", '0);
    @(posedge clk); #1;
    check("reset_held", '0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("reset_released", '0);
    @(posedge clk); #1;

    // Directed instructions
    run_instr(6'b000000, 0, 0);   // R-type, 4 clocks
    run_instr(6'b100011, 0, 3);   // lw with 3 stall clocks, 8 clocks
    run_instr(6'b000100, 0, 0);   // beq
    run_instr(6'b000010, 0, 0);   // j
    run_instr(6'b111111, 0, 0);   // illegal
    run_instr(6'b001000, 0, 0);   // addi (illegal unless enabled)
    run_instr(6'b101011, 2, 1);   // sw with fetch and write stalls

    // sw stalled in memory write, then reset mid-stall
    fetch_decode(6'b101011, 0, k);
    step("sw_addr", 1'b1, w_addr());
    step("sw_stall", 1'b0, w_mem(1'b1));
    step("sw_stall", 1'b0, w_mem(1'b1));
    #2 check("sw_stall_pre_reset", w_mem(1'b1));
    reset = 1'b1;
    #1 check("reset_mid_stall", '0);
    Mem_Ready = 1'b1;
    @(posedge clk); #1;
    check("reset_stall_held", '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_instr(6'b000000, 1, 0);   // restarts cleanly at fetch

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 7);
      op = (k < 6) ? ops[k] : 6'($urandom);
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the MIPS-32 datapath. Sits directly upstream of ALU_Control: it decodes the 6-bit opcode and sequences the datapath one phase per clock. It drives ALU_Op1/ALU_Op2 into ALU_Control and drives all mux, register-write and memory strobes. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

Parameters:
None. Opcode and state encodings are fixed constants in the shared package.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state S_RESET
Opcode  input  6  IR[31:26]; valid from S_DECODE onward
Mem_Ready  input  1  memory has completed the current read/write this cycle
PC_Write  output  1  unconditional PC load
PC_Write_Cond  output  1  PC load if ALU Zero
IorD  output  1  0=PC addresses memory, 1=ALUOut addresses memory
Mem_Read  output  1  memory read request
Mem_Write  output  1  memory write request
IR_Write  output  1  load instruction register
Mem_to_Reg  output  1  1=MDR to register file write data
Reg_Dst  output  1  1=rd, 0=rt
Reg_Write  output  1  register file write enable
ALU_Src_A  output  1  0=PC, 1=A register
ALU_Src_B  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALU_Op1  output  1  ALUOp[1] to ALU_Control
ALU_Op2  output  1  ALUOp[0] to ALU_Control
PC_Source  output  2  00=ALU result, 01=ALUOut, 10=jump target
Illegal_Op  output  1  one-cycle pulse in S_DECODE on an unsupported opcode

Behaviour:
- State register only; Moore outputs are decoded from the state, plus the Mem_Ready qualification noted below. Every output not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
- S_RESET: entered asynchronously while reset=1. All outputs 0. Goes to S_FETCH on the first clock after reset deasserts.
- S_FETCH: Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALUOp=00, PC_Source=00. IR_Write and PC_Write = Mem_Ready. Holds in S_FETCH while Mem_Ready=0, then goes to S_DECODE. The PC therefore increments exactly once per fetch.
- S_DECODE: ALU_Src_A=0, ALU_Src_B=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - lw/sw -> S_MEM_ADDR
  - R-type -> S_EXECUTE
  - beq -> S_BRANCH
  - j -> S_JUMP
  - other -> Illegal_Op=1, then S_FETCH (no architectural update)
- S_MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALUOp=00. Goes to S_MEM_READ for lw, S_MEM_WRITE for sw.
- S_MEM_READ: Mem_Read=1, IorD=1. Holds until Mem_Ready=1, then S_MEM_WB.
- S_MEM_WB: Reg_Write=1, Mem_to_Reg=1, Reg_Dst=0. Then S_FETCH.
- S_MEM_WRITE: Mem_Write=1, IorD=1. Holds until Mem_Ready=1, then S_FETCH. Mem_Write stays high and stable while stalled.
- S_EXECUTE: ALU_Src_A=1, ALU_Src_B=00, ALUOp=10 (funct decoded by ALU_Control). Then S_ALU_WB.
- S_ALU_WB: Reg_Write=1, Reg_Dst=1, Mem_to_Reg=0. Then S_FETCH.
- S_BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALUOp=01, PC_Write_Cond=1, PC_Source=01. Then S_FETCH.
- S_JUMP: PC_Write=1, PC_Source=10. Then S_FETCH.
- ALUOp=11 is never produced.
- Opcode is sampled only in S_DECODE and S_MEM_ADDR; it is don't-care elsewhere.
- Latency with Mem_Ready tied high, in clocks from entering S_FETCH to re-entering it:
  - R-type 4, lw 5, sw 4, beq 3, j 3
  - Each extra Mem_Ready=0 cycle adds one clock.
- Reset mid-instruction, including mid-stall: immediate S_RESET and all outputs 0. No partial write completes after reset assertion.
- Unreachable state encodings recover to S_FETCH on the next clock.

Optional Feature:
Macro: MIPS_CTRL_ADDI_EN
- Defined: opcode 001000 (addi) is supported. Path is S_DECODE -> S_ADDI_EXEC (ALU_Src_A=1, ALU_Src_B=10, ALUOp=00) -> S_ADDI_WB (Reg_Write=1, Reg_Dst=0, Mem_to_Reg=0) -> S_FETCH. Latency is 4 clocks.
- Undefined: the two states do not exist, and 001000 is illegal (Illegal_Op pulse, return to S_FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (4-bit encoding)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - ALU_Src_B and PC_Source encodings
- One sub-module, mips_ctrl_decode: purely combinational state-plus-Mem_Ready -> control-word decoder. The top keeps only the state register and next-state logic.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately. First clock after release: S_FETCH with Mem_Read=1, ALU_Src_B=01, ALUOp=00.
- R-type (Opcode=000000), Mem_Ready=1 -> 4-clock sequence. In S_EXECUTE: ALU_Op1=1, ALU_Op2=0, ALU_Src_A=1. In S_ALU_WB: Reg_Write=1, Reg_Dst=1. PC_Write pulses exactly once.
- lw (100011) with Mem_Ready=0 for 3 cycles in S_MEM_READ -> Mem_Read=1, IorD=1 held stable for 4 clocks. Then S_MEM_WB with Reg_Write=1, Mem_to_Reg=1. Total 8 clocks.
- beq (000100) -> S_BRANCH with ALU_Op1=0, ALU_Op2=1, PC_Write_Cond=1, PC_Source=01. j (000010) -> S_JUMP with PC_Write=1, PC_Source=10. Each takes 3 clocks.
- Opcode=111111 -> Illegal_Op=1 for exactly 1 cycle in S_DECODE, then S_FETCH. No Reg_Write, Mem_Write or PC_Write beyond the fetch increment.
- sw (101011) stalled in S_MEM_WRITE, reset asserted -> Mem_Write drops to 0 asynchronously. After release the FSM restarts at S_FETCH. With MIPS_CTRL_ADDI_EN defined, 001000 completes in 4 clocks with Reg_Dst=0.
